sdram_arbit_rr: RTL and testbench
=================================

// Module: sdram_arbit_rr
// PURPOSE
// - Next-generation SDRAM command arbiter. Sits between sdram_init, sdram_auto_ref and NUM_CH
//   generic client engines (read or write) and the single SDRAM command/address/DQ pins.
// - Priority: refresh first, then clients in round-robin order.
// - Adds over the previous arbiter: parametrised channel count and widths, fair rotation,
//   a per-grant timeout watchdog with a sticky error flag, and a registered grant index.
// PARAMETERS
// - NUM_CH   4    number of client channels (2..8)
// - DQ_W     32   SDRAM data bus width
// - ADDR_W   11   SDRAM address bus width
// - BA_W     2    bank address width
// - TMO_CYC  1024 max cycles a grant (AREF or client) may last; 0 disables the watchdog
// - IDX_W    $clog2(NUM_CH) width of the grant index (derived; do not override)
// PORTS
// - sys_clk      in   1            system clock; single clock domain
// - sys_rst      in   1            reset, asynchronous assert, active-high
// - init_cmd     in   4            init-phase command {cs_n,ras_n,cas_n,we_n}
// - init_ba      in   BA_W         init-phase bank address
// - init_addr    in   ADDR_W       init-phase address
// - init_end     in   1            initialisation done (level)
// - aref_req     in   1            auto-refresh request
// - aref_end     in   1            refresh finished (1-cycle pulse)
// - aref_cmd     in   4            refresh command
// - aref_ba      in   BA_W         refresh bank address
// - aref_addr    in   ADDR_W       refresh address
// - aref_en      out  1            refresh grant
// - ch_req       in   NUM_CH       per-channel request
// - ch_end       in   NUM_CH       per-channel transaction end (1-cycle pulse)
// - ch_cmd       in   4*NUM_CH     packed commands; channel k occupies [4k+3:4k]
// - ch_ba        in   BA_W*NUM_CH  packed bank addresses
// - ch_addr      in   ADDR_W*NUM_CH packed addresses
// - ch_dq_oe     in   NUM_CH       channel k drives DQ this cycle
// - ch_wr_data   in   DQ_W*NUM_CH  packed write data
// - ch_en        out  NUM_CH       one-hot channel grant
// - grant_idx    out  IDX_W        index of the current/last granted channel
// - tmo_err      out  1            sticky watchdog error
// - tmo_ch       out  IDX_W+1      MSB=1: AREF timed out; otherwise the timed-out channel
// - dq_in        out  DQ_W         sdram_dq sampled combinationally, for read engines
// - sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1  SDRAM control pins
// - sdram_ba     out  BA_W         SDRAM bank address pins
// - sdram_addr   out  ADDR_W       SDRAM address pins
// - sdram_dq     inout DQ_W        SDRAM data bus
// BEHAVIOUR
// - States (one-hot): IDLE, ARBIT, AREF, GRANT.
//   - IDLE->ARBIT when init_end=1.
//   - ARBIT->AREF when aref_req=1.
//   - Else ARBIT->GRANT when |ch_req; winner = first requester at or after rr_ptr, wrapping
//     from NUM_CH-1 to 0.
//   - AREF->ARBIT on aref_end or on timeout.
//   - GRANT->ARBIT on ch_end[grant_idx] or on timeout.
// - Grant timing:
//   - aref_en, ch_en and grant_idx are registered and change on the same edge as state.
//   - Grant rises on the edge leaving ARBIT and falls on the edge returning to ARBIT.
//   - ch_end of non-granted channels is ignored.
// - rr_ptr <= winner+1 (mod NUM_CH) at each grant; refresh does not move it.
// - At least one ARBIT (NOP) cycle separates consecutive grants, including end+req in the same cycle.
// - aref_req during GRANT waits until that grant ends, then wins ARBIT over every channel.
// - Command mux (combinational on state):
//   - IDLE  -> init_*
//   - AREF  -> aref_*
//   - GRANT -> ch_* slice [grant_idx]
//   - ARBIT -> CMD_NOP, ba all-ones, addr all-ones
// - sdram_dq = ch_wr_data[grant_idx] when state==GRANT && ch_dq_oe[grant_idx]; else 'z.
// - sdram_cke is constant 1.
// - Watchdog (TMO_CYC>0):
//   - Counter clears on grant and counts each cycle in AREF or GRANT.
//   - When it reaches TMO_CYC-1 with no end, on that edge: return to ARBIT, drop the grant,
//     set tmo_err=1 and capture tmo_ch.
//   - tmo_err clears only on reset. The counter saturates; it never wraps.
// - Reset (any time, including mid-grant):
//   - state=IDLE; aref_en=0; ch_en=0; grant_idx=0; rr_ptr=0; tmo_err=0; tmo_ch=0; counter=0.
//   - Outputs show init_* and DQ is tri-stated immediately.
//   - An in-flight client transaction is abandoned; the client resets from the same sys_rst.
// STRUCTURE
// - Package sdram_arbit_pkg: CMD_NOP=4'b0111, state one-hot localparams, cmd width 4.
// - Sub-module rr_pick:
//   - Combinational; inputs req[NUM_CH] and ptr[IDX_W].
//   - Outputs valid and idx (rotate, priority-encode, un-rotate).
// - Top holds the FSM, the grant registers, the watchdog counter and the output mux.
// TESTING
// - Init: hold init_end=0 for 50 cycles, then pulse it.
//   Expect init_cmd passed through, ARBIT one cycle later, and NOP 4'b0111 / addr 11'h7ff.
// - RR fairness (NUM_CH=4): ch_req=4'b1111 held, each ch_end after 5 cycles.
//   Expect grant order 0,1,2,3,0 and exactly one NOP cycle between grants.
// - Refresh priority: aref_req rises while ch2 is granted.
//   Expect AREF immediately after ch_end[2], ahead of pending ch3, and rr_ptr still 3 afterwards.
// - Watchdog: TMO_CYC=16, ch1 never ends.
//   Expect grant dropped after 16 GRANT cycles, tmo_err=1 and tmo_ch=1, with tmo_err staying 1.
// - DQ: ch0 granted with ch_dq_oe[0]=1, data 32'hA5A5_5A5A.
//   Expect sdram_dq=32'hA5A5_5A5A while asserted; 'z in ARBIT and while ch1 (not granted) asserts oe.
// - Reset mid-GRANT: assert sys_rst asynchronously.
//   Expect ch_en=0 and state IDLE without waiting for a clock edge, and tmo_err cleared.

Source files
------------

// File: rtl/sdram_arbit_pkg.sv
// Shared types and constants for the SDRAM command arbiter.
// Commands are {cs_n, ras_n, cas_n, we_n}; the state encoding is one-hot.
package sdram_arbit_pkg;

  localparam int CMD_W = 4;
  localparam logic [CMD_W-1:0] CMD_NOP = 4'b0111;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ARBIT = 4'b0010,
    ST_AREF  = 4'b0100,
    ST_GRANT = 4'b1000
  } state_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/sdram_arbit_rr_if.sv
// Client-channel bus between the engines and the arbiter: packed per-channel requests and
// commands, one-hot grant back; grants are registered, dq_in is combinational.
interface sdram_arbit_rr_if #(
  parameter int NUM_CH = 4,
  parameter int DQ_W   = 32,
  parameter int ADDR_W = 11,
  parameter int BA_W   = 2,
  parameter int IDX_W  = $clog2(NUM_CH)
);
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH-1:0]        ch_end;
  logic [4*NUM_CH-1:0]      ch_cmd;
  logic [BA_W*NUM_CH-1:0]   ch_ba;
  logic [ADDR_W*NUM_CH-1:0] ch_addr;
  logic [NUM_CH-1:0]        ch_dq_oe;
  logic [DQ_W*NUM_CH-1:0]   ch_wr_data;
  logic [NUM_CH-1:0]        ch_en;
  logic [IDX_W-1:0]         grant_idx;
  logic [DQ_W-1:0]          dq_in;

  modport master (
    output ch_req, ch_end, ch_cmd, ch_ba, ch_addr, ch_dq_oe, ch_wr_data,
    input  ch_en, grant_idx, dq_in
  );

  modport slave (
    input  ch_req, ch_end, ch_cmd, ch_ba, ch_addr, ch_dq_oe, ch_wr_data,
    output ch_en, grant_idx, dq_in
  );
endinterface

// File: rtl/sdram_arbit_rr_pick.sv
// Round-robin winner select: first requester at or after ptr, wrapping at NUM_CH-1.
// Purely combinational, zero latency.
module rr_pick #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              valid,
  output logic [IDX_W-1:0]  idx
);

  int j;

  // Scan from the far end so the requester closest to ptr is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      j = i + int'(ptr);
      if (j >= NUM_CH) j = j - NUM_CH;
      if (req[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sdram_arbit_rr.sv
// SDRAM command arbiter: refresh first, then round-robin clients, with a grant watchdog.
// Grants change one edge after the decision; one NOP cycle always separates grants.
module sdram_arbit_rr
  import sdram_arbit_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DQ_W    = 32,
  parameter int ADDR_W  = 11,
  parameter int BA_W    = 2,
  parameter int TMO_CYC = 1024,
  parameter int IDX_W   = $clog2(NUM_CH)
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [CMD_W-1:0]    init_cmd,
  input  logic [BA_W-1:0]     init_ba,
  input  logic [ADDR_W-1:0]   init_addr,
  input  logic                init_end,
  input  logic                aref_req,
  input  logic                aref_end,
  input  logic [CMD_W-1:0]    aref_cmd,
  input  logic [BA_W-1:0]     aref_ba,
  input  logic [ADDR_W-1:0]   aref_addr,
  output logic                aref_en,
  sdram_arbit_rr_if.slave     ch_bus,
  output logic                tmo_err,
  output logic [IDX_W:0]      tmo_ch,
  output logic                sdram_cke,
  output logic                sdram_cs_n,
  output logic                sdram_ras_n,
  output logic                sdram_cas_n,
  output logic                sdram_we_n,
  output logic [BA_W-1:0]     sdram_ba,
  output logic [ADDR_W-1:0]   sdram_addr,
  inout  wire  [DQ_W-1:0]     sdram_dq
);

  localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  state_t              state;
  logic [NUM_CH-1:0]   ch_en_q;
  logic [IDX_W-1:0]    grant_idx_q;
  logic [IDX_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]    tmo_cnt;
  logic                tmo_hit;
  logic                pick_vld;
  logic [IDX_W-1:0]    pick_idx;
  logic [CMD_W-1:0]    cmd_mux;
  logic [BA_W-1:0]     ba_mux;
  logic [ADDR_W-1:0]   addr_mux;
  logic                dq_drive;

  rr_pick #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_pick (
    .req   (ch_bus.ch_req),
    .ptr   (rr_ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign tmo_hit = (TMO_CYC != 0) && (tmo_cnt == CNT_W'(TMO_CYC - 1));

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= ST_IDLE;
      aref_en     <= 1'b0;
      ch_en_q     <= '0;
      grant_idx_q <= '0;
      rr_ptr      <= '0;
      tmo_err     <= 1'b0;
      tmo_ch      <= '0;
      tmo_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (init_end) state <= ST_ARBIT;
        end
        ST_ARBIT: begin
          tmo_cnt <= '0;
          if (aref_req) begin
            state   <= ST_AREF;
            aref_en <= 1'b1;
          end else if (pick_vld) begin
            state       <= ST_GRANT;
            ch_en_q     <= NUM_CH'(1) << pick_idx;
            grant_idx_q <= pick_idx;
            rr_ptr      <= IDX_W'(wrap_inc(int'(pick_idx), NUM_CH));
          end
        end
        ST_AREF: begin
          if (aref_end || tmo_hit) begin
            state   <= ST_ARBIT;
            aref_en <= 1'b0;
            if (!aref_end) begin
              tmo_err <= 1'b1;
              tmo_ch  <= {1'b1, {IDX_W{1'b0}}};
            end
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_GRANT: begin
          if (ch_bus.ch_end[grant_idx_q] || tmo_hit) begin
            state   <= ST_ARBIT;
            ch_en_q <= '0;
            if (!ch_bus.ch_end[grant_idx_q]) begin
              tmo_err <= 1'b1;
              tmo_ch  <= {1'b0, grant_idx_q};
            end
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_mux  = CMD_NOP;
    ba_mux   = '1;
    addr_mux = '1;
    case (state)
      ST_IDLE: begin
        cmd_mux  = init_cmd;
        ba_mux   = init_ba;
        addr_mux = init_addr;
      end
      ST_AREF: begin
        cmd_mux  = aref_cmd;
        ba_mux   = aref_ba;
        addr_mux = aref_addr;
      end
      ST_GRANT: begin
        cmd_mux  = ch_bus.ch_cmd[grant_idx_q*CMD_W +: CMD_W];
        ba_mux   = ch_bus.ch_ba[grant_idx_q*BA_W +: BA_W];
        addr_mux = ch_bus.ch_addr[grant_idx_q*ADDR_W +: ADDR_W];
      end
      default: ;
    endcase
  end

  assign dq_drive = (state == ST_GRANT) && ch_bus.ch_dq_oe[grant_idx_q];
  assign sdram_dq = dq_drive ? ch_bus.ch_wr_data[grant_idx_q*DQ_W +: DQ_W] : {DQ_W{1'bz}};

  assign ch_bus.dq_in     = sdram_dq;
  assign ch_bus.ch_en     = ch_en_q;
  assign ch_bus.grant_idx = grant_idx_q;

  assign sdram_cke = 1'b1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;
  assign sdram_ba   = ba_mux;
  assign sdram_addr = addr_mux;

endmodule

// File: tb/tb_sdram_arbit_rr.sv
// Directed bench for sdram_arbit_rr: init, round-robin, refresh priority, DQ, watchdog, reset.
module tb_sdram_arbit_rr;
  import sdram_arbit_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int DQ_W    = 32;
  localparam int ADDR_W  = 11;
  localparam int BA_W    = 2;
  localparam int IDX_W   = 2;
  localparam int TMO_CYC = 16;

  localparam logic [3:0]  INIT_CMD  = 4'b0010;
  localparam logic [1:0]  INIT_BA   = 2'd1;
  localparam logic [10:0] INIT_ADDR = 11'h123;
  localparam logic [3:0]  AREF_CMD  = 4'b0001;
  localparam logic [1:0]  AREF_BA   = 2'd2;
  localparam logic [10:0] AREF_ADDR = 11'h400;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b0;
  logic               init_end = 1'b0;
  logic               aref_req = 1'b0;
  logic               aref_end = 1'b0;
  logic               aref_en;
  logic               tmo_err;
  logic [IDX_W:0]     tmo_ch;
  logic               sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [BA_W-1:0]    sdram_ba;
  logic [ADDR_W-1:0]  sdram_addr;
  wire  [DQ_W-1:0]    sdram_dq;
  logic [3:0]         cmd_o;
  logic               mem_oe = 1'b0;
  logic [DQ_W-1:0]    mem_dat = '0;

  int n_cmp = 0;
  int n_bad = 0;

  sdram_arbit_rr_if #(.NUM_CH(NUM_CH), .DQ_W(DQ_W), .ADDR_W(ADDR_W), .BA_W(BA_W),
                      .IDX_W(IDX_W)) bus ();

  sdram_arbit_rr #(.NUM_CH(NUM_CH), .DQ_W(DQ_W), .ADDR_W(ADDR_W), .BA_W(BA_W),
                   .TMO_CYC(TMO_CYC)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .init_cmd    (INIT_CMD),
    .init_ba     (INIT_BA),
    .init_addr   (INIT_ADDR),
    .init_end    (init_end),
    .aref_req    (aref_req),
    .aref_end    (aref_end),
    .aref_cmd    (AREF_CMD),
    .aref_ba     (AREF_BA),
    .aref_addr   (AREF_ADDR),
    .aref_en     (aref_en),
    .ch_bus      (bus),
    .tmo_err     (tmo_err),
    .tmo_ch      (tmo_ch),
    .sdram_cke   (sdram_cke),
    .sdram_cs_n  (sdram_cs_n),
    .sdram_ras_n (sdram_ras_n),
    .sdram_cas_n (sdram_cas_n),
    .sdram_we_n  (sdram_we_n),
    .sdram_ba    (sdram_ba),
    .sdram_addr  (sdram_addr),
    .sdram_dq    (sdram_dq)
  );

  // SDRAM-side driver, used to prove the arbiter has released the bus.
  assign sdram_dq = mem_oe ? mem_dat : {DQ_W{1'bz}};
  assign cmd_o = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

  always #5 sys_clk = ~sys_clk;

  function automatic logic [3:0] exp_cmd(input int k);
    case (k)
      0:       return 4'b0100;
      1:       return 4'b0101;
      2:       return 4'b0110;
      default: return 4'b0011;
    endcase
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, "_cmd"},  64'(cmd_o), 64'(CMD_NOP));
    chk({tag, "_addr"}, 64'(sdram_addr), 64'h7ff);
    chk({tag, "_ba"},   64'(sdram_ba), 64'h3);
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit: bench did not reach its summary");
    $fatal(1, "time limit");
  end

  initial begin
    bus.ch_req     = '0;
    bus.ch_end     = '0;
    bus.ch_cmd     = {4'b0011, 4'b0110, 4'b0101, 4'b0100};
    bus.ch_ba      = {2'd3, 2'd2, 2'd1, 2'd0};
    bus.ch_addr    = {11'h013, 11'h012, 11'h011, 11'h010};
    bus.ch_dq_oe   = '0;
    bus.ch_wr_data = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'hA5A5_5A5A};

    // Reset state
    #1 sys_rst = 1'b1;
    #1;
    chk("rst_ch_en", 64'(bus.ch_en), 64'h0);
    chk("rst_aref_en", 64'(aref_en), 64'h0);
    chk("rst_grant_idx", 64'(bus.grant_idx), 64'h0);
    chk("rst_tmo_err", 64'(tmo_err), 64'h0);
    chk("rst_tmo_ch", 64'(tmo_ch), 64'h0);
    chk("rst_cke", 64'(sdram_cke), 64'h1);
    chk("rst_init_cmd", 64'(cmd_o), 64'(INIT_CMD));
    chk("rst_init_addr", 64'(sdram_addr), 64'(INIT_ADDR));
    repeat (2) tick();
    sys_rst = 1'b0;

    // Initialisation passthrough then a single-cycle init_end pulse
    repeat (50) tick();
    chk("init_cmd_hold", 64'(cmd_o), 64'(INIT_CMD));
    chk("init_ba_hold", 64'(sdram_ba), 64'(INIT_BA));
    init_end = 1'b1;
    tick();
    init_end = 1'b0;
    chk_nop("arbit_after_init");
    tick();
    chk_nop("arbit_stays");

    // Round-robin with all channels requesting: order 0,1,2,3,0
    bus.ch_req = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      int k;
      k = g % 4;
      chk($sformatf("rr%0d_ch_en", g), 64'(bus.ch_en), 64'(4'b0001 << k));
      chk($sformatf("rr%0d_idx", g), 64'(bus.grant_idx), 64'(k));
      chk($sformatf("rr%0d_cmd", g), 64'(cmd_o), 64'(exp_cmd(k)));
      chk($sformatf("rr%0d_addr", g), 64'(sdram_addr), 64'(11'h010 + k));
      repeat (3) tick();
      chk($sformatf("rr%0d_held", g), 64'(bus.ch_en), 64'(4'b0001 << k));
      bus.ch_end = 4'(4'b0001 << k);
      tick();
      bus.ch_end = '0;
      chk($sformatf("rr%0d_end_en", g), 64'(bus.ch_en), 64'h0);
      chk_nop($sformatf("rr%0d_gap", g));
      if (g < 4) tick();
    end

    // Refresh requested mid-grant of ch2 with ch3 pending
    bus.ch_req = 4'b1100;
    tick();
    chk("ref_ch2_idx", 64'(bus.grant_idx), 64'h2);
    aref_req   = 1'b1;
    bus.ch_end = 4'b1000;
    tick();
    bus.ch_end = '0;
    chk("ref_foreign_end", 64'(bus.ch_en), 64'b0100);
    chk("ref_wait_aref_en", 64'(aref_en), 64'h0);
    bus.ch_end = 4'b0100;
    tick();
    bus.ch_end = '0;
    chk_nop("ref_gap");
    tick();
    chk("ref_aref_en", 64'(aref_en), 64'h1);
    chk("ref_ch_en_low", 64'(bus.ch_en), 64'h0);
    chk("ref_cmd", 64'(cmd_o), 64'(AREF_CMD));
    chk("ref_addr", 64'(sdram_addr), 64'(AREF_ADDR));
    aref_req = 1'b0;
    repeat (2) tick();
    aref_end = 1'b1;
    tick();
    aref_end = 1'b0;
    chk("ref_done_aref_en", 64'(aref_en), 64'h0);
    chk_nop("ref_done");
    tick();
    chk("ref_ptr_ch3_idx", 64'(bus.grant_idx), 64'h3);
    chk("ref_ptr_ch3_cmd", 64'(cmd_o), 64'(exp_cmd(3)));
    bus.ch_req = '0;
    bus.ch_end = 4'b1000;
    tick();
    bus.ch_end = '0;

    // DQ drive only while the granted channel asserts oe
    bus.ch_req   = 4'b0001;
    bus.ch_dq_oe = 4'b0001;
    mem_oe  = 1'b1;
    mem_dat = 32'h1234_5678;
    #1;
    chk("dq_arbit_release", 64'(bus.dq_in), 64'h1234_5678);
    mem_oe = 1'b0;
    tick();
    bus.ch_req = '0;
    chk("dq_grant_idx", 64'(bus.grant_idx), 64'h0);
    chk("dq_drive", 64'(sdram_dq), 64'hA5A5_5A5A);
    chk("dq_in_loop", 64'(bus.dq_in), 64'hA5A5_5A5A);
    bus.ch_dq_oe = 4'b0010;
    mem_oe  = 1'b1;
    mem_dat = 32'h0F0F_F0F0;
    #1;
    chk("dq_foreign_oe", 64'(bus.dq_in), 64'h0F0F_F0F0);
    mem_oe       = 1'b0;
    bus.ch_dq_oe = '0;
    bus.ch_end   = 4'b0001;
    tick();
    bus.ch_end = '0;

    // Watchdog: ch1 never ends
    bus.ch_req = 4'b0010;
    tick();
    bus.ch_req = '0;
    chk("tmo_grant_idx", 64'(bus.grant_idx), 64'h1);
    repeat (15) tick();
    chk("tmo_cycle16_en", 64'(bus.ch_en), 64'b0010);
    chk("tmo_cycle16_err", 64'(tmo_err), 64'h0);
    tick();
    chk("tmo_drop_en", 64'(bus.ch_en), 64'h0);
    chk("tmo_err_set", 64'(tmo_err), 64'h1);
    chk("tmo_ch", 64'(tmo_ch), 64'h1);
    chk_nop("tmo_arbit");
    repeat (3) tick();
    chk("tmo_err_sticky", 64'(tmo_err), 64'h1);

    // Reset asserted asynchronously in the middle of a grant
    bus.ch_req   = 4'b0001;
    bus.ch_dq_oe = 4'b0001;
    tick();
    bus.ch_req = '0;
    chk("mid_grant_en", 64'(bus.ch_en), 64'b0001);
    chk("mid_grant_err", 64'(tmo_err), 64'h1);
    #2;
    sys_rst = 1'b1;
    mem_oe  = 1'b1;
    mem_dat = 32'h5555_AAAA;
    #1;
    chk("arst_ch_en", 64'(bus.ch_en), 64'h0);
    chk("arst_idle_cmd", 64'(cmd_o), 64'(INIT_CMD));
    chk("arst_tmo_err", 64'(tmo_err), 64'h0);
    chk("arst_tmo_ch", 64'(tmo_ch), 64'h0);
    chk("arst_dq_release", 64'(bus.dq_in), 64'h5555_AAAA);
    mem_oe       = 1'b0;
    bus.ch_dq_oe = '0;
    tick();
    sys_rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
